// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter
//   Multi-digit BCD event counter driven by the rising edges of a divided
//   clock (tickIn). tickIn is in the inClk domain, and its edges are detected
//   against a one-cycle-delayed copy.
//   Ports:
//     inClk      - system clock, all state updates on posedge
//     reset      - asynchronous, active-low
//     tickIn     - divider output (level), counted on 0->1
//     enable     - 1 = count detected edges, 0 = hold
//     upDown     - 1 = up, 0 = down
//     clear      - synchronous clear (highest priority)
//     load       - synchronous parallel load of loadValue
//     loadValue  - BCD load value, digit 0 in [3:0]
//     countOut   - registered BCD count
//     wrapPulse  - one-cycle pulse on 99..9 -> 0 or 0 -> 99..9
//     loadErr    - one-cycle pulse when a load holds a non-BCD nibble

// One BCD digit of the increment/decrement chain. cin means "this digit
// moves"; cout means it rolled over and the next digit must move too.
module bcd_digit_step (
   input  logic       up,
   input  logic       cin,
   input  logic [3:0] d,
   output logic [3:0] q,
   output logic       cout
);
   always_comb begin
      q    = d;
      cout = 1'b0;
      if (cin) begin
         if (up) begin
            if (d == 4'd9) begin
               q    = 4'd0;
               cout = 1'b1;
            end else begin
               q = d + 4'd1;
            end
         end else begin
            if (d == 4'd0) begin
               q    = 4'd9;
               cout = 1'b1;
            end else begin
               q = d - 4'd1;
            end
         end
      end
   end
endmodule

module bcd_tick_counter #(
   parameter int DIGITS = 2
) (
   input  logic                  inClk,
   input  logic                  reset,
   input  logic                  tickIn,
   input  logic                  enable,
   input  logic                  upDown,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   loadValue,
   output logic [4*DIGITS-1:0]   countOut,
   output logic                  wrapPulse,
   output logic                  loadErr
);
   logic [DIGITS-1:0][3:0] count_q, count_d, step_val, load_dig;
   logic [DIGITS:0]        carry;
   logic [DIGITS-1:0]      nib_ok;
   logic                   tick_prev_q, tick_prev_d;
   logic                   wrap_q, wrap_d;
   logic                   load_err_q, load_err_d;
   logic                   tick_edge, load_ok;

   assign load_dig = loadValue;
   assign carry[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_step u_dig (
         .up   (upDown),
         .cin  (carry[g]),
         .d    (count_q[g]),
         .q    (step_val[g]),
         .cout (carry[g+1])
      );
      assign nib_ok[g] = (load_dig[g] <= 4'd9);
   end

   assign load_ok   = &nib_ok;
   // tickIn is used live, so the count moves on the very edge that first
   // samples tickIn high.
   assign tick_edge = tickIn & ~tick_prev_q;

   always_comb begin
      count_d     = count_q;
      wrap_d      = 1'b0;
      load_err_d  = 1'b0;
      tick_prev_d = tickIn;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         // A rejected load still consumes the cycle: any tick is dropped.
         if (load_ok) count_d    = load_dig;
         else         load_err_d = 1'b1;
      end else if (tick_edge && enable) begin
         count_d = step_val;
         wrap_d  = carry[DIGITS];
      end
   end

   always_ff @(posedge inClk or negedge reset) begin
      if (!reset) begin
         count_q     <= '0;
         wrap_q      <= 1'b0;
         load_err_q  <= 1'b0;
         // Start "high" so a tickIn already at 1 on release is not an edge.
         tick_prev_q <= 1'b1;
      end else begin
         count_q     <= count_d;
         wrap_q      <= wrap_d;
         load_err_q  <= load_err_d;
         tick_prev_q <= tick_prev_d;
      end
   end

   assign countOut  = count_q;
   assign wrapPulse = wrap_q;
   assign loadErr   = load_err_q;
endmodule

// File: tb/tb_bcd_tick_counter.sv
// Testbench for bcd_tick_counter: directed scenarios plus random traffic,
// scored against a decimal-integer reference model through an expectation
// queue drained by an independent monitor.
module tb_bcd_tick_counter;
   localparam int DIGITS = 2;
   localparam int MOD    = 100;

   logic       inClk = 1'b0;
   logic       reset = 1'b0;
   logic       tickIn = 1'b0, enable = 1'b0, upDown = 1'b1;
   logic       clear = 1'b0, load = 1'b0;
   logic [7:0] loadValue = 8'h00;
   logic [7:0] countOut;
   logic       wrapPulse, loadErr;

   bcd_tick_counter #(.DIGITS(DIGITS)) dut (
      .inClk(inClk), .reset(reset), .tickIn(tickIn), .enable(enable),
      .upDown(upDown), .clear(clear), .load(load), .loadValue(loadValue),
      .countOut(countOut), .wrapPulse(wrapPulse), .loadErr(loadErr)
   );

   always #5 inClk = ~inClk;

   typedef struct {
      logic [7:0] c;
      logic       w;
      logic       e;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state: plain decimal count and last sampled tickIn
   int   m_cnt  = 0;
   bit   m_prev = 1'b1;

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      int         x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle's inputs (called just after a negedge), advance the
   // model, queue the expected post-edge outputs, then move to next negedge.
   task automatic cyc(input bit t, input bit en, input bit ud, input bit clr,
                      input bit ld, input logic [7:0] lv);
      bit   edg, w, e, ok;
      int   val;
      exp_t x;
      tickIn = t; enable = en; upDown = ud; clear = clr; load = ld; loadValue = lv;
      edg = t && !m_prev;
      m_prev = t;
      w = 0; e = 0;
      ok = (lv[3:0] <= 9) && (lv[7:4] <= 9);
      val = lv[7:4] * 10 + lv[3:0];
      if (clr) m_cnt = 0;
      else if (ld) begin
         if (ok) m_cnt = val;
         else e = 1;
      end else if (edg && en) begin
         if (ud) begin
            w = (m_cnt == MOD - 1);
            m_cnt = (m_cnt + 1) % MOD;
         end else begin
            w = (m_cnt == 0);
            m_cnt = (m_cnt + MOD - 1) % MOD;
         end
      end
      x.c = to_bcd(m_cnt); x.w = w; x.e = e;
      q.push_back(x);
      @(posedge inClk);
      @(negedge inClk);
   endtask

   task automatic idle(input bit t, input int n, input bit ud);
      for (int i = 0; i < n; i++) cyc(t, 1, ud, 0, 0, 8'h00);
   endtask

   task automatic pulse(input bit ud);   // one clean 0->1 tick edge
      cyc(0, 1, ud, 0, 0, 8'h00);
      cyc(1, 1, ud, 0, 0, 8'h00);
   endtask

   task automatic do_load(input logic [7:0] v);
      cyc(tickIn, 1, upDown, 0, 1, v);
   endtask

   task automatic release_reset();
      @(negedge inClk);
      reset  = 1'b1;
      m_cnt  = 0;
      m_prev = 1'b1;
   endtask

   // monitor: compare every queued expectation just after the clock edge
   always @(posedge inClk) begin
      exp_t x;
      #1;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("count", countOut, x.c);
         chk("wrapPulse", {7'b0, wrapPulse}, {7'b0, x.w});
         chk("loadErr", {7'b0, loadErr}, {7'b0, x.e});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      // reset state
      #12;
      chk("reset_count", countOut, 8'h00);
      chk("reset_flags", {6'b0, wrapPulse, loadErr}, 8'h00);
      release_reset();

      // count to 23 with a period-10 divider waveform
      for (int i = 0; i < 230; i++) cyc((i % 10) >= 5, 1, 1, 0, 0, 8'h00);
      chk("count_to_23", countOut, 8'h23);

      // up wrap
      do_load(8'h98);
      pulse(1); pulse(1);
      // down wrap
      do_load(8'h01);
      pulse(0); pulse(0);
      do_load(8'h10);
      pulse(0);
      chk("down_borrow", countOut, 8'h09);

      // load rejection then valid load
      do_load(8'h42);
      cyc(0, 1, 1, 0, 1, 8'h3A);
      chk("rej_hold", countOut, 8'h42);
      cyc(0, 1, 1, 0, 1, 8'h57);

      // simultaneous events
      do_load(8'h20);
      cyc(0, 1, 1, 0, 0, 8'h00);
      cyc(1, 1, 1, 0, 1, 8'h10);      // tick + load
      chk("tick_load", countOut, 8'h10);
      cyc(0, 1, 1, 0, 0, 8'h00);
      cyc(1, 1, 1, 1, 1, 8'h55);      // tick + clear + load
      chk("tick_clr_load", countOut, 8'h00);
      cyc(0, 1, 1, 0, 0, 8'h00);
      cyc(1, 0, 1, 0, 0, 8'h00);      // edge while disabled
      idle(1, 4, 1);                  // enabled, tickIn still high
      chk("lost_edge", countOut, 8'h00);
      pulse(1);

      // tickIn held high across reset release
      reset = 1'b0;
      tickIn = 1'b1;
      @(negedge inClk);
      release_reset();
      idle(1, 5, 1);
      chk("hi_release", countOut, 8'h00);
      pulse(1);

      // async reset mid-count at 57, between edges
      do_load(8'h57);
      idle(0, 2, 1);
      #2 reset = 1'b0;
      #1 chk("async_rst_cnt", countOut, 8'h00);
      release_reset();

      // async reset clears a pending wrap pulse
      do_load(8'h99);
      pulse(1);                       // wrapPulse now high
      #2 reset = 1'b0;
      #1 chk("async_rst_wrap", {7'b0, wrapPulse}, 8'h00);
      release_reset();

      // randomized traffic
      begin
         bit t = 0, ud = 1;
         for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 2) == 0) t = ~t;
            if ($urandom_range(0, 30) == 0) ud = ~ud;
            cyc(t, $urandom_range(0, 7) != 0, ud,
                $urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0,
                8'($urandom));
         end
      end

      @(negedge inClk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain actual=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
- Synchronous BCD event counter that sits directly downstream of the clock divider.
- Runs on the same fast clock, inClk, and takes the divider's slow square-wave output as a level input, tickIn.
- Each rising edge of tickIn is detected in the inClk domain and advances a multi-digit BCD count, up or down.
- Feeds display/decoder logic; provides load, clear and a wrap indication.

Parameters:
DIGITS, 2, number of BCD digits; count width is 4*DIGITS bits, range 0 to 10^DIGITS-1

Ports:
inClk  input  1  system clock; all state updates on posedge inClk
reset  input  1  asynchronous, active-low reset; reset==0 forces reset state immediately
tickIn  input  1  divided clock from the divider, same clock domain (registered on inClk); not resynchronised
enable  input  1  1 = count on detected tick edges; 0 = hold count
upDown  input  1  1 = count up, 0 = count down; sampled on the counting edge
clear  input  1  synchronous clear of count to zero
load  input  1  synchronous parallel load
loadValue  input  4*DIGITS  BCD load value; digit i in bits [4i+3:4i], digit 0 = least significant
countOut  output  4*DIGITS  registered BCD count
wrapPulse  output  1  one-cycle pulse on wrap-around
loadErr  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset==0, asynchronous):
  - countOut=0, wrapPulse=0, loadErr=0.
  - Internal tickPrev=1, so a tickIn already high at reset release is not counted.
- Edge detect: tickEdge = tickIn & ~tickPrev, evaluated combinationally from the current tickIn. tickPrev<=tickIn every cycle, regardless of enable, clear or load.
- Latency: the count changes on the same inClk posedge at which tickIn is first sampled 1 after being 0. countOut reflects the new value one clock after the divider's outClk register rises. Exactly one increment per tickIn rising edge, independent of tickIn high time.
- Priority per cycle, highest first: clear > load > tick.
  - clear=1: countOut<=0. Load and tick are discarded; the tick is lost, not deferred.
  - load=1, every loadValue nibble <=9: countOut<=loadValue. Tick discarded.
  - load=1, any nibble >9: countOut unchanged, loadErr<=1 for one cycle. Tick in the same cycle is also discarded.
  - tickEdge & enable: count by one, as below.
  - Otherwise countOut holds.
- Up count:
  - Digit 0 adds 1; a digit at 9 becomes 0 and carries into the next digit.
  - All digits 9 -> all 0, and wrapPulse<=1.
- Down count:
  - Digit 0 subtracts 1; a digit at 0 becomes 9 and borrows from the next digit.
  - All digits 0 -> all 9, and wrapPulse<=1.
- wrapPulse and loadErr are registered and high for exactly one cycle; both are 0 in every cycle without the triggering event.
- enable=0: edges are still tracked through tickPrev. An edge occurring while enable=0 is lost and is not counted when enable returns.
- Digits are never outside 0..9 in any reachable state.
- Reset mid-operation: asynchronous; any pending pulse is cleared immediately. The first tick after release requires a fresh 0->1 transition of tickIn.

Test Plan:
- Count to 23: reset low, release with tickIn=0; drive tickIn as divider output (period 10 inClk); enable=1, upDown=1 -> 23 rising edges give countOut=8'h23. Each change occurs on the edge where tickIn first samples 1.
- Up wrap: load 8'h98, then 2 tick edges -> countOut 8'h99 then 8'h00, with wrapPulse high exactly on the 8'h00 cycle.
- Down wrap: load 8'h01, upDown=0, 2 tick edges -> 8'h00 then 8'h99, with wrapPulse on the 8'h99 cycle. Loading 8'h10 then one down tick -> 8'h09.
- Load rejection: count at 8'h42, load=1 with loadValue=8'h3A -> countOut stays 8'h42 and loadErr pulses for one cycle. Then loadValue=8'h57 -> countOut=8'h57, loadErr=0.
- Simultaneous events: tick edge in the same cycle as load 8'h10 -> countOut=8'h10, not 8'h11. Tick edge with clear=1 and load=1 -> countOut=8'h00. Tick edge with enable=0, then enable=1 with tickIn still high -> no count until the next rising edge.
- Reset: hold tickIn=1 across reset release -> no count until tickIn falls and rises again. Assert reset mid-count at 8'h57 between clock edges -> countOut=0 immediately, with no clock edge required.
